// File: rtl/mem_access.sv
// Load/store stage: non-memory ops pass through in 1 cycle; ld/st run one req/ack dmem transaction (min 2 cycles to result).
// Backpressure: stall_o holds execute for every BUSY cycle; an optional timeout aborts a hung transaction and sets err_o.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [31:0]       result_i,
  input  logic [31:0]       st_data_i,
  input  logic [3:0]        rd_addr_i,
  input  logic              wb_en_i,
  input  logic              ld_i,
  input  logic              st_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              wb_en_o,
  output logic [3:0]        rd_addr_o,
  output logic [31:0]       wb_data_o,
  output logic              err_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                is_ld_q, is_ld_d;
  logic [3:0]          rd_cap_q, rd_cap_d;
  logic                wb_en_q, wb_en_d;
  logic [3:0]          rd_addr_q, rd_addr_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                err_q, err_d;

  // Upper result bits only matter for pass-through data, not for the address.
  logic unused_addr_hi;
  assign unused_addr_hi = ^result_i[31:ADDR_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_ld_d   = is_ld_q;
    rd_cap_d  = rd_cap_q;
    wb_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (ld_i && st_i) begin
            err_d = 1'b1;
          end else if (ld_i || st_i) begin
            state_d  = BUSY;
            we_d     = st_i;
            addr_d   = result_i[ADDR_W-1:0];
            wdata_d  = st_data_i;
            is_ld_d  = ld_i;
            rd_cap_d = rd_addr_i;
          end else begin
            wb_en_d   = wb_en_i;
            rd_addr_d = rd_addr_i;
            wb_data_d = result_i;
          end
        end
      end
      BUSY: begin
        // Ack takes priority over the timeout limit in the same cycle.
        if (dmem_ack_i) begin
          state_d = IDLE;
          if (is_ld_q) begin
            wb_en_d   = 1'b1;
            rd_addr_d = rd_cap_q;
            wb_data_d = dmem_rdata_i;
          end
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_ld_q   <= 1'b0;
      rd_cap_q  <= '0;
      wb_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_ld_q   <= is_ld_d;
      rd_cap_q  <= rd_cap_d;
      wb_en_q   <= wb_en_d;
      rd_addr_q <= rd_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign stall_o      = (state_q == BUSY);
  assign dmem_req_o   = (state_q == BUSY);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_en_o      = wb_en_q;
  assign rd_addr_o    = rd_addr_q;
  assign wb_data_o    = wb_data_q;
  assign err_o        = err_q;

endmodule
